rc4_prga_engine: RTL and testbench

RC4_PRGA_ENGINE -- requirements
Module: rc4_prga_engine

---
 rtl/rc4_pkg.sv | 24 ++
 rtl/rc4_char_check.sv | 17 +
 rtl/rc4_prga_engine.sv | 147 ++++++++++++++
 tb/tb_rc4_prga_engine.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// RC4 keystream engine shared types.
// FSM states and default plaintext character window.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INC,
    RDI,
    LATI,
    RDJ,
    LATJ,
    WRI,
    WRJ,
    RDF,
    LATF,
    OUT,
    DONE
  } state_t;

  localparam logic [7:0] CHAR_LO_D = 8'h61;
  localparam logic [7:0] CHAR_HI_D = 8'h7A;
  localparam logic [7:0] CHAR_SP_D = 8'h20;

endpackage

// File: rtl/rc4_char_check.sv
// Plaintext legality test: byte inside [lo,hi] or equal to the
// extra accepted byte.
module rc4_char_check
  import rc4_pkg::*;
#(
  parameter logic [7:0] CHAR_LO = CHAR_LO_D,
  parameter logic [7:0] CHAR_HI = CHAR_HI_D,
  parameter logic [7:0] CHAR_SP = CHAR_SP_D
) (
  input  logic [7:0] data,
  output logic       legal
);

  assign legal = ((data >= CHAR_LO) && (data <= CHAR_HI))
              || (data == CHAR_SP);

endmodule

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA: one keystream byte per 10 cycles, XORed with ROM
// ciphertext and written to the plaintext RAM.
module rc4_prga_engine
  import rc4_pkg::*;
#(
  parameter int         MSG_LEN  = 32,
  parameter int         K_W      = 5,
  parameter bit         CHECK_EN = 1'b1,
  parameter logic [7:0] CHAR_LO  = CHAR_LO_D,
  parameter logic [7:0] CHAR_HI  = CHAR_HI_D,
  parameter logic [7:0] CHAR_SP  = CHAR_SP_D
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [7:0]     s_addr,
  output logic [7:0]     s_wdata,
  output logic           s_wren,
  input  logic [7:0]     s_rdata,
  output logic [K_W-1:0] rom_addr,
  input  logic [7:0]     rom_rdata,
  output logic [K_W-1:0] out_addr,
  output logic [7:0]     out_wdata,
  output logic           out_wren
);

  localparam logic [K_W-1:0] K_LAST = K_W'(MSG_LEN - 1);

  state_t         state, nxt;
  logic [7:0]     i, j, si, sj, f, c;
  logic [K_W-1:0] k;
  logic [7:0]     plain;
  logic           legal;
  logic           abort;

  assign plain = f ^ c;
  assign abort = CHECK_EN && !legal;

  rc4_char_check #(
    .CHAR_LO(CHAR_LO),
    .CHAR_HI(CHAR_HI),
    .CHAR_SP(CHAR_SP)
  ) u_check (
    .data (plain),
    .legal(legal)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      si    <= '0;
      sj    <= '0;
      f     <= '0;
      c     <= '0;
      pass  <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: if (start) begin
          i    <= '0;
          j    <= '0;
          k    <= '0;
          pass <= 1'b1;
        end
        INC:  i <= i + 8'd1;
        LATI: begin
          si <= s_rdata;
          j  <= j + s_rdata;
        end
        LATJ: sj <= s_rdata;
        LATF: begin
          f <= s_rdata;
          c <= rom_rdata;
        end
        OUT: begin
          if (abort) pass <= 1'b0;
          else if (k != K_LAST) k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt       = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wren    = 1'b0;
    rom_addr  = '0;
    out_addr  = '0;
    out_wdata = '0;
    out_wren  = 1'b0;
    unique case (state)
      IDLE: if (start) nxt = INC;
      INC:  nxt = RDI;
      RDI: begin
        s_addr = i;
        nxt    = LATI;
      end
      LATI: nxt = RDJ;
      RDJ: begin
        s_addr = j;
        nxt    = LATJ;
      end
      LATJ: nxt = WRI;
      WRI: begin
        s_addr  = i;
        s_wdata = sj;
        s_wren  = 1'b1;
        nxt     = WRJ;
      end
      WRJ: begin
        s_addr  = j;
        s_wdata = si;
        s_wren  = 1'b1;
        nxt     = RDF;
      end
      RDF: begin
        s_addr   = si + sj;
        rom_addr = k;
        nxt      = LATF;
      end
      LATF: nxt = OUT;
      OUT: begin
        out_addr  = k;
        out_wdata = plain;
        out_wren  = 1'b1;
        // an illegal byte is still written before the run stops
        nxt = (abort || k == K_LAST) ? DONE : INC;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Bench for rc4_prga_engine: four configurations side by side,
// each with its own S-RAM, ROM and plaintext RAM.
module tb_rc4_prga_engine;

  localparam int NI = 4;
  localparam logic [3:0][15:0] ML = {16'd300, 16'd1, 16'd9, 16'd9};
  localparam logic [3:0][3:0]  KW = {4'd9, 4'd1, 4'd4, 4'd4};
  localparam logic [3:0]       CE = 4'b0110;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic [NI-1:0] start, busy, done, pass, s_wren, out_wren, load;
  logic [7:0] s_addr_m [NI];
  logic [7:0] sram  [NI][256];
  logic [7:0] pre_s [NI][256];
  logic [7:0] rom   [NI][512];
  logic [7:0] outm  [NI][512];
  int owr_cnt [NI];
  int swr_cnt [NI];

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int KWG = int'(KW[g]);
    logic [7:0] sa, swd, srd, rd, owd;
    logic [KWG-1:0] ra, oa;

    rc4_prga_engine #(
      .MSG_LEN (int'(ML[g])),
      .K_W     (KWG),
      .CHECK_EN(CE[g])
    ) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .pass     (pass[g]),
      .s_addr   (sa),
      .s_wdata  (swd),
      .s_wren   (s_wren[g]),
      .s_rdata  (srd),
      .rom_addr (ra),
      .rom_rdata(rd),
      .out_addr (oa),
      .out_wdata(owd),
      .out_wren (out_wren[g])
    );

    assign s_addr_m[g] = sa;

    always @(posedge clock) begin
      if (load[g]) begin
        for (int x = 0; x < 256; x++) sram[g][x] <= pre_s[g][x];
        for (int x = 0; x < 512; x++) outm[g][x] <= 8'hEE;
        owr_cnt[g] <= 0;
        swr_cnt[g] <= 0;
      end else begin
        if (s_wren[g]) begin
          sram[g][sa] <= swd;
          swr_cnt[g]  <= swr_cnt[g] + 1;
        end
        if (out_wren[g]) begin
          outm[g][oa] <= owd;
          owr_cnt[g]  <= owr_cnt[g] + 1;
        end
      end
      srd <= sram[g][sa];
      rd  <= rom[g][ra];
    end
  end

  int vecs, errs;
  logic [7:0] sref   [256];
  logic [7:0] exp_s  [256];
  logic [7:0] exp_pt [512];
  logic [7:0] pt     [512];
  int exp_n;
  bit exp_pass;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
  endfunction

  // Textbook RC4 PRGA on a private copy of S.
  task automatic model(input int g, input int len, input bit chkf);
    int ii, jj;
    logic [7:0] t, p;
    for (int x = 0; x < 256; x++) exp_s[x] = sref[x];
    ii = 0; jj = 0; exp_n = 0; exp_pass = 1'b1;
    for (int k = 0; k < len; k++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(exp_s[ii])) % 256;
      t = exp_s[ii]; exp_s[ii] = exp_s[jj]; exp_s[jj] = t;
      t = exp_s[(int'(exp_s[ii]) + int'(exp_s[jj])) % 256];
      p = t ^ rom[g][k];
      exp_pt[k] = p;
      exp_n++;
      if (chkf && !legal(p)) begin
        exp_pass = 1'b0;
        break;
      end
    end
  endtask

  task automatic preload(input int g);
    for (int x = 0; x < 256; x++) pre_s[g][x] = sref[x];
    @(negedge clock); load[g] = 1'b1;
    @(negedge clock); load[g] = 1'b0;
  endtask

  task automatic encode(input int g);
    for (int k = 0; k < int'(ML[g]); k++) rom[g][k] = 8'h00;
    model(g, int'(ML[g]), 1'b0);
    for (int k = 0; k < int'(ML[g]); k++) rom[g][k] = exp_pt[k] ^ pt[k];
  endtask

  task automatic rand_perm();
    logic [7:0] t;
    int r;
    for (int x = 0; x < 256; x++) sref[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = sref[x]; sref[x] = sref[r]; sref[r] = t;
    end
  endtask

  task automatic check_run(input int g, input string tag, input bit poke);
    int cyc, nd, diffs;
    model(g, int'(ML[g]), CE[g]);
    preload(g);
    @(negedge clock); start[g] = 1'b1; cyc = 0;
    while (cyc < 4000) begin
      @(negedge clock);
      cyc++;
      start[g] = poke && (cyc == 5 || cyc == 50);
      if (done[g]) break;
    end
    start[g] = 1'b0;
    chk({tag, ".cycles"}, cyc, 10 * exp_n + 1);
    chk({tag, ".pass_done"}, pass[g], exp_pass);
    nd = 0;
    repeat (20) begin
      @(negedge clock);
      if (done[g]) nd++;
    end
    chk({tag, ".extra_done"}, nd, 0);
    chk({tag, ".busy_after"}, busy[g], 1'b0);
    chk({tag, ".pass_held"}, pass[g], exp_pass);
    chk({tag, ".writes"}, owr_cnt[g], exp_n);
    for (int k = 0; k < exp_n; k++)
      chk($sformatf("%s.out[%0d]", tag, k), outm[g][k], exp_pt[k]);
    diffs = 0;
    for (int x = 0; x < 256; x++)
      if (sram[g][x] !== exp_s[x]) diffs++;
    chk({tag, ".sram_diffs"}, diffs, 0);
  endtask

  initial begin
    logic [7:0] ct [9];
    logic [7:0] key [3];
    logic [7:0] bp [9];
    string txt;
    int jj, cyc, pos, r;
    logic [7:0] t;

    vecs = 0; errs = 0;
    start = '0; load = '0; reset_n = 1'b0;
    #1;
    chk("rst.busy", busy, 4'h0);
    chk("rst.done", done, 4'h0);
    chk("rst.pass", pass, 4'h0);
    chk("rst.s_wren", s_wren, 4'h0);
    chk("rst.out_wren", out_wren, 4'h0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // identity S, single byte
    for (int x = 0; x < 256; x++) sref[x] = 8'(x);
    rom[2][0] = 8'h63;
    check_run(2, "ident1", 1'b0);
    chk("ident1.byte", outm[2][0], 8'h61);

    // classic "Key"/"Plaintext" vector
    key = '{8'h4B, 8'h65, 8'h79};
    for (int x = 0; x < 256; x++) sref[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(sref[x]) + int'(key[x % 3])) % 256;
      t = sref[x]; sref[x] = sref[jj]; sref[jj] = t;
    end
    ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int k = 0; k < 9; k++) begin
      rom[0][k] = ct[k];
      rom[1][k] = ct[k];
    end
    check_run(0, "key", 1'b0);
    txt = "Plaintext";
    for (int k = 0; k < 9; k++)
      chk($sformatf("key.text[%0d]", k), outm[0][k], txt[k]);
    check_run(1, "keychk", 1'b0);
    chk("keychk.byte", outm[1][0], 8'h50);
    chk("keychk.count", owr_cnt[1], 1);

    // window edges: 'a','z',' ' legal, '`' and '{' not
    bp = '{8'h61, 8'h7A, 8'h20, 8'h61, 8'h7A, 8'h20, 8'h61, 8'h7A, 8'h60};
    for (int k = 0; k < 9; k++) pt[k] = bp[k];
    encode(1);
    check_run(1, "edge60", 1'b0);
    chk("edge60.pass", pass[1], 1'b0);
    pt[1] = 8'h7B;
    encode(1);
    check_run(1, "edge7b", 1'b0);

    // 300 bytes across the i wrap, with stray starts mid-run
    for (int x = 0; x < 256; x++) sref[x] = 8'(x);
    for (int k = 0; k < 300; k++) rom[3][k] = 8'($urandom);
    check_run(3, "wrap", 1'b1);
    rand_perm();
    for (int k = 0; k < 300; k++) rom[3][k] = 8'($urandom);
    check_run(3, "wraprnd", 1'b0);

    // random S and ciphertext, checker off
    for (int n = 0; n < 3; n++) begin
      rand_perm();
      for (int k = 0; k < 9; k++) rom[0][k] = 8'($urandom);
      check_run(0, $sformatf("rnd%0d", n), 1'b0);
    end

    // random legal text, sometimes one illegal byte
    for (int n = 0; n < 4; n++) begin
      rand_perm();
      for (int k = 0; k < 9; k++) begin
        r = $urandom_range(26, 0);
        pt[k] = (r == 26) ? 8'h20 : 8'h61 + 8'(r);
      end
      pos = $urandom_range(11, 0);
      if (pos < 9) pt[pos] = 8'h30 + 8'($urandom_range(9, 0));
      encode(1);
      check_run(1, $sformatf("chk%0d", n), 1'b0);
    end

    // reset in WRI of byte 3
    rand_perm();
    for (int k = 0; k < 9; k++) rom[0][k] = 8'($urandom);
    preload(0);
    @(negedge clock); start[0] = 1'b1; cyc = 0;
    while (cyc < 36) begin
      @(negedge clock);
      cyc++;
      start[0] = 1'b0;
    end
    chk("rst3.in_wri", s_wren[0], 1'b1);
    chk("rst3.i", s_addr_m[0], 8'd4);
    reset_n = 1'b0;
    #1;
    chk("rst3.busy", busy[0], 1'b0);
    chk("rst3.done", done[0], 1'b0);
    chk("rst3.pass", pass[0], 1'b0);
    chk("rst3.s_wren", s_wren[0], 1'b0);
    chk("rst3.out_wren", out_wren[0], 1'b0);
    chk("rst3.s_addr", s_addr_m[0], 8'd0);
    repeat (3) @(negedge clock);
    chk("rst3.swr", swr_cnt[0], 6);
    chk("rst3.owr", owr_cnt[0], 3);
    reset_n = 1'b1;
    check_run(0, "after_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
